boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Hand-off sequencer between the USB bootloader core and the ECP5 reconfiguration pin on the ULX3S board. It consumes the bootloader's `boot` request, or an optional no-host timeout. It waits for the USB transmitter to go quiet, then takes over the flash SPI pins and sends a software reset (0x66, 0x99) to the flash. After a programmable delay it drives `user_programn` low, which reboots into the user image. Outside the hand-off, the bootloader's SPI signals pass through unchanged.

## Interface
Parameters:
- `TX_QUIET_CYCLES`, default 480: contiguous `usb_tx_en`-low cycles required before the hand-off proceeds (10 µs at 48 MHz).
- `PROG_DELAY`, default 256: cycles between the end of the flash reset and `user_programn` going low.
- `AUTOBOOT_CYCLES`, default 144_000_000: timeout with no USB activity (3 s). Used only with `AUTOBOOT_TIMEOUT_EN`.

Ports:
- `clk_48mhz`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `boot_req`  in  1  boot request from the bootloader; the first high cycle latches it.
- `usb_tx_en`  in  1  USB transmitter output enable.
- `usb_activity`  in  1  one-cycle pulse per received USB packet.
- `spi_cs_in`, `spi_sck_in`, `spi_mosi_in`  in  1 each  bootloader SPI master outputs.
- `spi_cs`, `spi_sck`, `spi_mosi`  out  1 each  to the flash (`spi_sck` feeds USRMCLK).
- `user_programn`  out  1  low triggers reconfiguration.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, QUIET, CMD, GAP, DELAY, PROG.
- Reset values:
  - state is IDLE, all counters are 0.
  - `user_programn` = 1, `busy` = 0.
  - SPI outputs are in pass-through, so `spi_cs` follows `spi_cs_in`.
- IDLE → QUIET: on `boot_req`, or on autoboot expiry.
- QUIET:
  - The quiet counter counts up while `usb_tx_en` = 0 and clears to 0 whenever `usb_tx_en` = 1.
  - When the counter reaches `TX_QUIET_CYCLES - 1`, go to CMD with byte index 0.
- CMD:
  - The block owns the SPI pins: `spi_cs` = 0, and the `*_in` inputs are ignored.
  - The byte is sent MSB first in SPI mode 0. Each bit takes 2 cycles: `spi_sck` = 0 with `spi_mosi` driving the bit, then `spi_sck` = 1.
  - After 16 cycles, go to GAP.
- GAP:
  - `spi_cs` = 1, `spi_sck` = 0 for 4 cycles.
  - Then: if the byte index is 0, move to byte index 1 and return to CMD. Otherwise go to DELAY.
- DELAY: counts `PROG_DELAY` cycles with `spi_cs` = 1, then goes to PROG.
- PROG:
  - `user_programn` = 0, `spi_cs` = 1.
  - Terminal state; only `reset` leaves it.
- Pin ownership: from QUIET through PROG, the SPI pins are owned by the block. In QUIET they are held at the idle level (`spi_cs` = 1, `spi_sck` = 0, `spi_mosi` = 0).
- Further `boot_req` and `usb_activity` inputs are ignored once the state has left IDLE.
- Reset asserted mid-operation (e.g. during CMD): all outputs return to their reset values asynchronously. `spi_cs` rises immediately; the partial command is abandoned.

## Timing
- All state and outputs are registered.
- Latencies:
  - `boot_req` high at cycle N gives `busy` = 1 at N+1.
  - With `usb_tx_en` held low, first `spi_cs` = 0 occurs at N+1+`TX_QUIET_CYCLES`.
- Flash reset sequence: CMD 16 + GAP 4 + CMD 16 + GAP 4 = 40 cycles.
- `user_programn` falls `PROG_DELAY` cycles after the final GAP ends.
- Counters:
  - Widths are sized by `$clog2` of their parameter.
  - Counters saturate and never wrap.
- Simultaneous `boot_req` and autoboot expiry: a single QUIET entry.

## Configuration
- `BOOT_SEQUENCER_AUTOBOOT_TIMEOUT_EN` defined:
  - In IDLE, a counter increments every cycle and clears on `usb_activity`.
  - When it reaches `AUTOBOOT_CYCLES - 1`, the block enters QUIET exactly as for `boot_req`.
- Undefined: only `boot_req` leaves IDLE; the counter and `usb_activity` logic are not synthesised.

## Structure
- Package `boot_sequencer_pkg` holds:
  - the state enum;
  - opcode constants `FLASH_RST_EN` = 8'h66 and `FLASH_RST` = 8'h99;
  - `GAP_CYCLES` = 4.
- One sub-module, `spi_byte_tx`: start/done handshake, 16-cycle mode-0 byte shifter. The FSM, counters and pin mux stay in `boot_sequencer`.

## Test plan
- **Reset:** `reset` pulse → `user_programn` = 1, `busy` = 0; `spi_cs` follows a toggling `spi_cs_in`.
- **Boot, quiet bus:** `boot_req` pulse with `usb_tx_en` = 0 → bytes 0x66 then 0x99 observed on MOSI at SCK rising edges, `spi_cs` high for 4 cycles between them; `user_programn` falls exactly 256 cycles after the final GAP ends.
- **TX activity:** `boot_req` pulse, then `usb_tx_en` = 1 at quiet count 300 → quiet count restarts; first `spi_cs` fall occurs 480 cycles after `usb_tx_en` drops.
- **Reset mid-CMD:** `reset` asserted 5 cycles into the second CMD → `spi_cs` = 1 asynchronously, state IDLE, pass-through restored, `user_programn` = 1.
- **Autoboot (macro on, `AUTOBOOT_CYCLES` = 1000):** no `usb_activity` → QUIET entered after 1000 cycles; a `usb_activity` pulse at cycle 900 → expiry delayed to 1000 cycles after the pulse.
- **Late requests:** `boot_req` reasserted during DELAY → no effect on timing; PROG is reached once and `user_programn` stays 0.

Source files
------------

// File: rtl/boot_sequencer_pkg.sv
// rtl/boot_sequencer_pkg.sv - shared types and constants for the bootloader-to-user-image hand-off
//
// Holds the sequencer state enum, the two flash software-reset opcodes, the
// inter-byte chip-select gap length and a counter-width helper.

package boot_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUIET = 3'd1,
        S_CMD   = 3'd2,
        S_GAP   = 3'd3,
        S_DELAY = 3'd4,
        S_PROG  = 3'd5
    } state_t;

    localparam logic [7:0] FLASH_RST_EN = 8'h66;
    localparam logic [7:0] FLASH_RST    = 8'h99;

    localparam int GAP_CYCLES = 4;
    localparam int GAP_W      = $clog2(GAP_CYCLES);

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_sequencer_spi_byte_tx.sv
// rtl/boot_sequencer_spi_byte_tx.sv - 16-cycle SPI mode-0 byte shifter, MSB first
//
// Ports:
//   clk_48mhz  in   clock
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle pulse; loads data, first bit appears next cycle
//   data[7:0]  in   byte to send, sampled on start
//   done       out  high during the 16th (last) cycle of the byte
//   sck        out  registered serial clock, low on bit setup, high on bit hold
//   mosi       out  registered serial data (top of the shift register)

module spi_byte_tx (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       sck,
    output logic       mosi
);

    logic [3:0] cyc;
    logic       active;
    logic [7:0] shreg;
    logic       sck_q;

    // Even cycles put the bit out with sck low, odd cycles raise sck; the
    // shift happens when leaving an odd cycle so mosi is stable around the
    // rising edge the flash samples on.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            cyc    <= 4'd0;
            active <= 1'b0;
            shreg  <= 8'h00;
            sck_q  <= 1'b0;
        end else if (start) begin
            cyc    <= 4'd0;
            active <= 1'b1;
            shreg  <= data;
            sck_q  <= 1'b0;
        end else if (active) begin
            if (!cyc[0]) begin
                sck_q <= 1'b1;
                cyc   <= cyc + 4'd1;
            end else if (cyc == 4'd15) begin
                sck_q  <= 1'b0;
                shreg  <= 8'h00;
                active <= 1'b0;
                cyc    <= 4'd0;
            end else begin
                sck_q <= 1'b0;
                shreg <= {shreg[6:0], 1'b0};
                cyc   <= cyc + 4'd1;
            end
        end
    end

    assign done = active && (cyc == 4'd15);
    assign sck  = sck_q;
    assign mosi = shreg[7];

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - hands the flash SPI pins from the USB bootloader to a reset-and-reconfigure sequence
//
// Optional feature macro: BOOT_SEQUENCER_AUTOBOOT_TIMEOUT_EN (no-host autoboot timeout).
//
// Ports:
//   clk_48mhz      in   sole clock
//   reset          in   asynchronous active-high reset
//   boot_req       in   boot request from the bootloader, first high cycle latches it
//   usb_tx_en      in   USB transmitter output enable; must stay low for the quiet window
//   usb_activity   in   one-cycle pulse per received packet (autoboot timeout restart)
//   spi_cs_in      in   bootloader SPI chip select
//   spi_sck_in     in   bootloader SPI clock
//   spi_mosi_in    in   bootloader SPI data
//   spi_cs         out  flash chip select
//   spi_sck        out  flash clock (USRMCLK)
//   spi_mosi       out  flash data
//   user_programn  out  low triggers FPGA reconfiguration
//   busy           out  high in every state except IDLE

module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int TX_QUIET_CYCLES = 480,
    parameter int PROG_DELAY      = 256,
    parameter int AUTOBOOT_CYCLES = 144_000_000
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic boot_req,
    input  logic usb_tx_en,
    input  logic usb_activity,
    input  logic spi_cs_in,
    input  logic spi_sck_in,
    input  logic spi_mosi_in,
    output logic spi_cs,
    output logic spi_sck,
    output logic spi_mosi,
    output logic user_programn,
    output logic busy
);

    localparam int QW = cnt_width(TX_QUIET_CYCLES);
    localparam int DW = cnt_width(PROG_DELAY);

    localparam logic [QW-1:0]    QUIET_LAST = QW'(TX_QUIET_CYCLES - 1);
    localparam logic [DW-1:0]    DELAY_LAST = DW'(PROG_DELAY - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [QW-1:0]    quiet_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [DW-1:0]    delay_cnt;
    logic             byte_idx;
    logic             cs_q;
    logic             busy_q;
    logic             programn_q;

    logic       auto_fire;
    logic       quiet_done;
    logic       gap_done;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       tx_sck;
    logic       tx_mosi;

`ifdef BOOT_SEQUENCER_AUTOBOOT_TIMEOUT_EN
    localparam int AW = cnt_width(AUTOBOOT_CYCLES);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOBOOT_CYCLES - 1);

    logic [AW-1:0] auto_cnt;

    // Runs only while idle; any received packet means a host is present.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (state != S_IDLE || usb_activity) begin
            auto_cnt <= '0;
        end else if (auto_cnt != '1) begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign auto_fire = (state == S_IDLE) && !usb_activity && (auto_cnt == AUTO_LAST);
`else
    logic unused_autoboot;
    assign unused_autoboot = usb_activity ^ (AUTOBOOT_CYCLES > 0);
    assign auto_fire       = 1'b0;
`endif

    // The shifter must load on the same edge the FSM enters CMD so that
    // cs falls together with the first bit.
    assign quiet_done = (state == S_QUIET) && !usb_tx_en && (quiet_cnt == QUIET_LAST);
    assign gap_done   = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign tx_start   = quiet_done || (gap_done && !byte_idx);
    assign tx_byte    = (state == S_QUIET) ? FLASH_RST_EN : FLASH_RST;

    spi_byte_tx u_spi_byte_tx (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .start     (tx_start),
        .data      (tx_byte),
        .done      (tx_done),
        .sck       (tx_sck),
        .mosi      (tx_mosi)
    );

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            quiet_cnt  <= '0;
            gap_cnt    <= '0;
            delay_cnt  <= '0;
            byte_idx   <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            programn_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (boot_req || auto_fire) begin
                        state     <= S_QUIET;
                        quiet_cnt <= '0;
                        cs_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_QUIET: begin
                    if (usb_tx_en) begin
                        quiet_cnt <= '0;
                    end else if (quiet_cnt == QUIET_LAST) begin
                        state    <= S_CMD;
                        byte_idx <= 1'b0;
                        cs_q     <= 1'b0;
                    end else if (quiet_cnt != '1) begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                S_CMD: begin
                    if (tx_done) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                        cs_q    <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (!byte_idx) begin
                            state    <= S_CMD;
                            byte_idx <= 1'b1;
                            cs_q     <= 1'b0;
                        end else begin
                            state     <= S_DELAY;
                            delay_cnt <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == DELAY_LAST) begin
                        state      <= S_PROG;
                        programn_q <= 1'b0;
                    end else if (delay_cnt != '1) begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                S_PROG: begin
                    programn_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // busy_q doubles as pin ownership: the block owns the SPI pins in every
    // non-IDLE state. Reset clears it asynchronously, so pass-through returns
    // without waiting for a clock.
    assign spi_cs        = busy_q ? cs_q    : spi_cs_in;
    assign spi_sck       = busy_q ? tx_sck  : spi_sck_in;
    assign spi_mosi      = busy_q ? tx_mosi : spi_mosi_in;
    assign user_programn = programn_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed self-checking bench for boot_sequencer

module tb_boot_sequencer;

    localparam int TQ = 480;
    localparam int PD = 256;
    localparam int AC = 1000;

    logic clk_48mhz = 1'b0;
    logic reset = 1'b1;
    logic boot_req = 1'b0;
    logic usb_tx_en = 1'b0;
    logic usb_activity = 1'b0;
    logic spi_cs_in = 1'b1;
    logic spi_sck_in = 1'b0;
    logic spi_mosi_in = 1'b0;
    logic spi_cs, spi_sck, spi_mosi, user_programn, busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    boot_sequencer #(
        .TX_QUIET_CYCLES (TQ),
        .PROG_DELAY      (PD),
        .AUTOBOOT_CYCLES (AC)
    ) dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .boot_req      (boot_req),
        .usb_tx_en     (usb_tx_en),
        .usb_activity  (usb_activity),
        .spi_cs_in     (spi_cs_in),
        .spi_sck_in    (spi_sck_in),
        .spi_mosi_in   (spi_mosi_in),
        .spi_cs        (spi_cs),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .user_programn (user_programn),
        .busy          (busy)
    );

    always #5 clk_48mhz = ~clk_48mhz;
    always @(posedge clk_48mhz) cyc <= cyc + 1;

    typedef struct {
        logic cs_in, sck_in, mosi_in, tx_en;
        logic exp_cs, exp_sck, exp_mosi, exp_programn, exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled only on falling edges.
    task automatic do_reset();
        boot_req = 1'b0;
        usb_tx_en = 1'b0;
        usb_activity = 1'b0;
        reset = 1'b1;
        @(negedge clk_48mhz);
        @(negedge clk_48mhz);
        reset = 1'b0;
    endtask

    // which: 0 = spi_cs low, 1 = busy high, 2 = user_programn low. at = -1 on timeout.
    task automatic wait_until(input int which, input int budget, output int at);
        bit hit;
        hit = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !hit; i++) begin
            if ((which == 0 && spi_cs === 1'b0) || (which == 1 && busy === 1'b1) ||
                (which == 2 && user_programn === 1'b0)) begin
                hit = 1'b1;
                at = cyc;
            end else begin
                @(negedge clk_48mhz);
            end
        end
    endtask

    // Pass-through inputs are driven opposite to the owned idle levels so any leak shows.
    task automatic start_boot(output int n);
        spi_cs_in = 1'b0;
        spi_sck_in = 1'b1;
        spi_mosi_in = 1'b1;
        usb_tx_en = 1'b0;
        chk("idle_busy", busy, 0);
        boot_req = 1'b1;
        n = cyc;
        @(negedge clk_48mhz);
        boot_req = 1'b0;
        chk("busy_latency", busy, 1);
        chk("quiet_cs", spi_cs, 1);
        chk("quiet_sck", spi_sck, 0);
        chk("quiet_mosi", spi_mosi, 0);
    endtask

    task automatic run_boot(input bit late_req);
        int n, fall, gap_last, prog_at;
        logic [7:0] op;
        start_boot(n);
        wait_until(0, 2000, fall);
        chk("first_cs_fall_cycle", fall, n + 1 + TQ);
        gap_last = -1;
        for (int b = 0; b < 2; b++) begin
            op = (b == 0) ? 8'h66 : 8'h99;
            for (int k = 0; k < 16; k++) begin
                chk("cmd_cs", spi_cs, 0);
                chk("cmd_sck", spi_sck, k % 2);
                chk("cmd_mosi", spi_mosi, op[7 - k / 2]);
                @(negedge clk_48mhz);
            end
            for (int g = 0; g < 4; g++) begin
                chk("gap_cs", spi_cs, 1);
                chk("gap_sck", spi_sck, 0);
                if (g == 3) gap_last = cyc;
                @(negedge clk_48mhz);
            end
        end
        chk("delay_cs", spi_cs, 1);
        prog_at = -1;
        for (int i = 0; i < 1000 && prog_at < 0; i++) begin
            if (user_programn === 1'b0) begin
                prog_at = cyc;
            end else begin
                boot_req = late_req && (i == 50);
                @(negedge clk_48mhz);
            end
        end
        boot_req = 1'b0;
        chk("programn_delay", prog_at - (gap_last + 1), PD);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) boot_req = late_req;
            if (i == 4) boot_req = 1'b0;
            if (i % 5 == 0) begin
                chk("prog_programn", user_programn, 0);
                chk("prog_busy", busy, 1);
                chk("prog_cs", spi_cs, 1);
            end
            @(negedge clk_48mhz);
        end
    endtask

    initial begin
        int n, m, fall, at, r, p;
        bit seen;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state, pass-through while reset is held.
        @(negedge clk_48mhz);
        chk("rst_programn", user_programn, 1);
        chk("rst_busy", busy, 0);
        spi_cs_in = 1'b0;
        #1 chk("rst_cs_follow_lo", spi_cs, 0);
        spi_cs_in = 1'b1;
        #1 chk("rst_cs_follow_hi", spi_cs, 1);
        do_reset();

        // Idle pass-through table.
        for (int i = 0; i < 6; i++) begin
            spi_cs_in = vecs[i].cs_in;
            spi_sck_in = vecs[i].sck_in;
            spi_mosi_in = vecs[i].mosi_in;
            usb_tx_en = vecs[i].tx_en;
            @(negedge clk_48mhz);
            chk("vec_cs", spi_cs, vecs[i].exp_cs);
            chk("vec_sck", spi_sck, vecs[i].exp_sck);
            chk("vec_mosi", spi_mosi, vecs[i].exp_mosi);
            chk("vec_programn", user_programn, vecs[i].exp_programn);
            chk("vec_busy", busy, vecs[i].exp_busy);
        end

        // Boot on a quiet bus, then again with late requests during DELAY and PROG.
        do_reset();
        run_boot(1'b0);
        do_reset();
        run_boot(1'b1);

        // TX activity at quiet count 300 restarts the quiet window.
        do_reset();
        start_boot(n);
        repeat (300) @(negedge clk_48mhz);
        usb_tx_en = 1'b1;
        repeat (10) @(negedge clk_48mhz);
        chk("tx_hold_cs", spi_cs, 1);
        usb_tx_en = 1'b0;
        m = cyc;
        wait_until(0, 2000, fall);
        chk("tx_restart_cs_fall", fall, m + TQ);

        // Reset five cycles into the second command byte.
        do_reset();
        start_boot(n);
        wait_until(0, 2000, fall);
        repeat (20) @(negedge clk_48mhz);
        chk("second_cmd_cs", spi_cs, 0);
        repeat (5) @(negedge clk_48mhz);
        spi_cs_in = 1'b1;
        spi_sck_in = 1'b1;
        spi_mosi_in = 1'b1;
        #1 chk("pre_reset_cs_owned", spi_cs, 0);
        reset = 1'b1;
        #1 chk("async_cs_high", spi_cs, 1);
        chk("async_sck_pass", spi_sck, 1);
        chk("async_mosi_pass", spi_mosi, 1);
        chk("async_programn", user_programn, 1);
        chk("async_busy", busy, 0);
        spi_cs_in = 1'b0;
        #1 chk("async_cs_follow", spi_cs, 0);
        @(negedge clk_48mhz);
        reset = 1'b0;
        repeat (5) @(negedge clk_48mhz);
        chk("post_reset_idle", busy, 0);
        chk("post_reset_cs_follow", spi_cs, 0);
        spi_cs_in = 1'b1;

`ifdef BOOT_SEQUENCER_AUTOBOOT_TIMEOUT_EN
        // Counter is 0 in the release cycle, so QUIET begins AC cycles later.
        do_reset();
        r = cyc;
        wait_until(1, 1500, at);
        chk("autoboot_expiry", at, r + AC);
        // A pulse in cycle p clears the count for cycle p+1.
        do_reset();
        r = cyc;
        repeat (900) @(negedge clk_48mhz);
        usb_activity = 1'b1;
        p = cyc;
        @(negedge clk_48mhz);
        usb_activity = 1'b0;
        wait_until(1, 1500, at);
        chk("autoboot_after_activity", at, p + 1 + AC);
`else
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (busy !== 1'b0) seen = 1'b1;
            @(negedge clk_48mhz);
        end
        chk("no_autoboot", seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
